// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port, debug port and memory port of the
// data-memory arbiter, bundled with arbiter/environment modports.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cpu_stall;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory
// between the CPU data port and the debug/loader port.
module dmem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_chk
      $error("dmem_arbiter: MEM_LAT must be 1..7");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   state_t        state;
   logic          owner;
   logic          rr;
   logic [2:0]    cnt;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_ack;
   logic          dbg_ack;
   logic [DW-1:0] cpu_rdata;
   logic [DW-1:0] dbg_rdata;

   logic          grant_dbg;
   logic          any_req;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // rr = 1 means debug has priority when both request
   always_comb begin
      any_req   = bus.cpu_req | bus.dbg_req;
      grant_dbg = bus.dbg_req & (~bus.cpu_req | rr);
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      unique case (1'b1)
         grant_dbg: begin
            sel_we    = bus.dbg_we;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= 1'b0;
         rr        <= 1'b0;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= grant_dbg;
                  rr        <= ~grant_dbg;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               cnt    <= 3'd1;
               state  <= WAIT;
            end
            WAIT: begin
               if (cnt == LAT) begin
                  if (!mem_we) begin
                     if (owner) dbg_rdata <= bus.mem_rdata;
                     else       cpu_rdata <= bus.mem_rdata;
                  end
                  dbg_ack <= owner;
                  cpu_ack <= ~owner;
                  state   <= RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            RESP: begin
               cpu_ack <= 1'b0;
               dbg_ack <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.cpu_ack   = cpu_ack;
   assign bus.dbg_ack   = dbg_ack;
   assign bus.cpu_rdata = cpu_rdata;
   assign bus.dbg_rdata = dbg_rdata;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench, one instance at MEM_LAT=1 and
// one at MEM_LAT=4, with a latency-accurate memory model.
module tb_dmem_arbiter;

   localparam logic [31:0] POISON = 32'h0BAD_0BAD;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter_if #(.AW(32), .DW(32)) ia ();
   dmem_arbiter_if #(.AW(32), .DW(32)) ib ();

   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .bus(ia.slave)
   );
   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ib.slave)
   );

   function automatic logic [31:0] memf(logic [31:0] a);
      if (a == 32'h40) return 32'hDEAD_BEEF;
      if (a == 32'h08) return 32'hCAFE_F00D;
      return a ^ 32'h5A5A_0000;
   endfunction

   // read data appears exactly MEM_LAT cycles after mem_en, poison otherwise
   logic [31:0] pa;
   logic [31:0] pb [4];
   always @(posedge clk) begin
      pa    <= (ia.mem_en && !ia.mem_we) ? memf(ia.mem_addr) : POISON;
      pb[0] <= (ib.mem_en && !ib.mem_we) ? memf(ib.mem_addr) : POISON;
      for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
   end
   assign ia.mem_rdata = pa;
   assign ib.mem_rdata = pb[3];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic        dbg;
      logic [31:0] cpu_rd;
      logic [31:0] dbg_rd;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] last_cpu = '0;
   logic [31:0] last_dbg = '0;

   task automatic push_a(logic dbg, logic we, logic [31:0] a);
      exp_t e;
      if (!we) begin
         if (dbg) last_dbg = memf(a);
         else     last_cpu = memf(a);
      end
      e.dbg    = dbg;
      e.cpu_rd = last_cpu;
      e.dbg_rd = last_dbg;
      qa.push_back(e);
   endtask

   task automatic flush_a();
      qa.delete();
      last_cpu = '0;
      last_dbg = '0;
   endtask

   int          en_cnt = 0;
   int          en_cyc = 0;
   logic        en_we;
   logic [31:0] en_addr;
   logic [31:0] en_wdata;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("stall", ia.cpu_stall, ia.cpu_req & ~ia.cpu_ack);
            if (ia.mem_en) begin
               en_cnt++;
               en_cyc   = cyc;
               en_we    = ia.mem_we;
               en_addr  = ia.mem_addr;
               en_wdata = ia.mem_wdata;
            end
            if (ia.cpu_ack || ia.dbg_ack) begin
               chk("ack_excl", ia.cpu_ack & ia.dbg_ack, 0);
               if (qa.size() == 0) begin
                  chk("ack_unexp", 1, 0);
               end else begin
                  e = qa.pop_front();
                  chk("owner", ia.dbg_ack, e.dbg);
                  chk("cpu_rdata", ia.cpu_rdata, e.cpu_rd);
                  chk("dbg_rdata", ia.dbg_rdata, e.dbg_rd);
               end
            end
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack_a(output int c);
      c = -1;
      for (int k = 0; k < 40; k++) begin
         nxt();
         if (ia.cpu_ack || ia.dbg_ack) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) chk("ack_timeout", 1, 0);
   endtask

   task automatic cpu_go(logic we, logic [31:0] a, logic [31:0] d);
      ia.cpu_we    = we;
      ia.cpu_addr  = a;
      ia.cpu_wdata = d;
      ia.cpu_req   = 1'b1;
   endtask

   task automatic dbg_go(logic we, logic [31:0] a, logic [31:0] d);
      ia.dbg_we    = we;
      ia.dbg_addr  = a;
      ia.dbg_wdata = d;
      ia.dbg_req   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, c, e0, ack_prev, nack, enb, ackb;
      exp_t eb;
      reset = 1'b0;
      {ia.cpu_req, ia.cpu_we, ia.dbg_req, ia.dbg_we} = '0;
      {ia.cpu_addr, ia.cpu_wdata, ia.dbg_addr, ia.dbg_wdata} = '0;
      {ib.cpu_req, ib.cpu_we, ib.dbg_req, ib.dbg_we} = '0;
      {ib.cpu_addr, ib.cpu_wdata, ib.dbg_addr, ib.dbg_wdata} = '0;
      repeat (2) nxt();
      chk("rst_mem_en", ia.mem_en, 0);
      chk("rst_mem_we", ia.mem_we, 0);
      chk("rst_mem_addr", ia.mem_addr, 0);
      chk("rst_mem_wdata", ia.mem_wdata, 0);
      chk("rst_acks", {ia.cpu_ack, ia.dbg_ack}, 0);
      chk("rst_rdata", ia.cpu_rdata | ia.dbg_rdata, 0);
      chk("rst_b_en", ib.mem_en, 0);
      reset = 1'b1;
      nxt();

      // CPU read, MEM_LAT=1
      t0 = cyc;
      e0 = en_cnt;
      cpu_go(1'b0, 32'h40, 32'h0);
      push_a(1'b0, 1'b0, 32'h40);
      #1 chk("t1_stall0", ia.cpu_stall, 1);
      wait_ack_a(c);
      chk("t1_en_cyc", en_cyc - t0, 1);
      chk("t1_ack_cyc", c - t0, 3);
      chk("t1_en_cnt", en_cnt - e0, 1);
      chk("t1_stall3", ia.cpu_stall, 0);
      ia.cpu_req = 1'b0;

      // CPU write
      nxt();
      e0 = en_cnt;
      cpu_go(1'b1, 32'h10, 32'h1234);
      push_a(1'b0, 1'b1, 32'h10);
      wait_ack_a(c);
      ia.cpu_req = 1'b0;
      chk("t2_en_cnt", en_cnt - e0, 1);
      chk("t2_ack_lag", c - en_cyc, 2);
      chk("t2_we", en_we, 1);
      chk("t2_addr", en_addr, 32'h10);
      chk("t2_wdata", en_wdata, 32'h1234);

      // reset asserted while in WAIT
      nxt();
      cpu_go(1'b0, 32'h40, 32'h0);
      push_a(1'b0, 1'b0, 32'h40);
      nxt();
      nxt();
      reset = 1'b0;
      #1;
      flush_a();
      chk("t5_mem_en", ia.mem_en, 0);
      chk("t5_acks", {ia.cpu_ack, ia.dbg_ack}, 0);
      chk("t5_addr", ia.mem_addr, 0);
      chk("t5_rdata", ia.cpu_rdata, 0);
      chk("t5_stall", ia.cpu_stall, 1);
      nxt();
      reset = 1'b1;
      t0 = cyc;
      push_a(1'b0, 1'b0, 32'h40);
      wait_ack_a(c);
      ia.cpu_req = 1'b0;
      chk("t5_ack_cyc", c - t0, 3);

      // both rise together after reset: C, D, C, D
      nxt();
      reset = 1'b0;
      nxt();
      reset = 1'b1;
      flush_a();
      nxt();
      t0 = cyc;
      cpu_go(1'b0, 32'h100, 32'h0);
      dbg_go(1'b0, 32'h200, 32'h0);
      push_a(1'b0, 1'b0, 32'h100);
      push_a(1'b1, 1'b0, 32'h200);
      push_a(1'b0, 1'b0, 32'h100);
      push_a(1'b1, 1'b0, 32'h200);
      ack_prev = t0 - 1;
      for (int i = 0; i < 4; i++) begin
         wait_ack_a(c);
         chk("t3_spacing", c - ack_prev, (i == 0) ? 4 : 4);
         ack_prev = c;
         if (i == 2) ia.cpu_req = 1'b0;
         if (i == 3) ia.dbg_req = 1'b0;
      end
      chk("t3_drained", qa.size(), 0);

      // debug drops req in ISSUE, access still completes
      nxt();
      t0 = cyc;
      dbg_go(1'b0, 32'h08, 32'h0);
      push_a(1'b1, 1'b0, 32'h08);
      nxt();
      ia.dbg_req = 1'b0;
      wait_ack_a(c);
      chk("t6_ack_cyc", c - t0, 3);
      nxt();
      cpu_go(1'b0, 32'h100, 32'h0);
      dbg_go(1'b0, 32'h200, 32'h0);
      push_a(1'b0, 1'b0, 32'h100);
      push_a(1'b1, 1'b0, 32'h200);
      wait_ack_a(c);
      ia.cpu_req = 1'b0;
      wait_ack_a(c);
      ia.dbg_req = 1'b0;

      // single CPU grant hands priority to debug
      nxt();
      cpu_go(1'b0, 32'h300, 32'h0);
      push_a(1'b0, 1'b0, 32'h300);
      wait_ack_a(c);
      ia.cpu_req = 1'b0;
      nxt();
      cpu_go(1'b0, 32'h100, 32'h0);
      dbg_go(1'b0, 32'h200, 32'h0);
      push_a(1'b1, 1'b0, 32'h200);
      push_a(1'b0, 1'b0, 32'h100);
      wait_ack_a(c);
      ia.dbg_req = 1'b0;
      wait_ack_a(c);
      ia.cpu_req = 1'b0;
      nxt();
      chk("t7_drained", qa.size(), 0);

      // MEM_LAT=4 debug read
      nxt();
      t0   = cyc;
      enb  = -1;
      ackb = -1;
      nack = 0;
      ib.dbg_we   = 1'b0;
      ib.dbg_addr = 32'h08;
      ib.dbg_req  = 1'b1;
      eb.dbg    = 1'b1;
      eb.cpu_rd = '0;
      eb.dbg_rd = memf(32'h08);
      qb.push_back(eb);
      for (int k = 1; k <= 14; k++) begin
         nxt();
         if (ib.mem_en) enb = cyc;
         if (ib.cpu_ack) chk("t4_cpu_ack", 1, 0);
         if (ib.dbg_ack) begin
            nack++;
            ackb = cyc;
            ib.dbg_req = 1'b0;
            if (qb.size() == 0) begin
               chk("t4_ack_unexp", 1, 0);
            end else begin
               eb = qb.pop_front();
               chk("t4_rdata", ib.dbg_rdata, eb.dbg_rd);
               chk("t4_cpu_rdata", ib.cpu_rdata, eb.cpu_rd);
            end
         end
      end
      chk("t4_en_cyc", enb - t0, 1);
      chk("t4_ack_cyc", ackb - t0, 6);
      chk("t4_nack", nack, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
